// File: rtl/spi_avmm_pkg.sv
// Shared types and constants for the SPI-slave to Avalon-MM bridge.
// Optional burst auto-increment is selected with SPI_AVMM_AUTOINC_EN.
package spi_avmm_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned CMD_W_BIT = 7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_RD_REQ = 3'd2,
    ST_DATA   = 3'd3,
    ST_WR_REQ = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic                 RST_SCK  = 1'b0;
  localparam logic                 RST_CS_N = 1'b1;
  localparam logic                 RST_MOSI = 1'b0;
  localparam logic                 RST_MISO = 1'b0;
  localparam logic                 RST_BIT  = 1'b0;
  localparam logic [BYTE_W-1:0]    RST_BYTE = '0;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BYTE_W - 1);

  function automatic logic is_last_bit(input logic [BIT_CNT_W-1:0] cnt);
    return cnt == LAST_BIT;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous SPI pin, with rise/fall pulses
// derived from the synchronised level.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise_c,
  output logic o_fall_c
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("spi_sync_edge: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_q      = r_sync[SYNC_STAGES-1];
  assign o_rise_c =  r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall_c = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule

// File: rtl/spi_avmm_bridge8.sv
// SPI mode-0 slave that turns a command byte plus a data byte into one 8-bit
// Avalon-MM read or write. Define SPI_AVMM_AUTOINC_EN for address-incrementing bursts.
module spi_avmm_bridge8
  import spi_avmm_pkg::*;
#(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              csi_MCLK_clk,
  input  logic              rsi_MRST_reset,
  input  logic              coe_SPI_sck,
  input  logic              coe_SPI_cs_n,
  input  logic              coe_SPI_mosi,
  output logic              coe_SPI_miso,
  output logic [ADDR_W-1:0] avm_M1_address,
  output logic              avm_M1_read,
  output logic              avm_M1_write,
  output logic [BYTE_W-1:0] avm_M1_writedata,
  input  logic [BYTE_W-1:0] avm_M1_readdata,
  input  logic              avm_M1_waitrequest
);

  logic w_sck_rise;
  logic w_sck_fall;
  logic w_sck_q_unused;
  logic w_cs_q;
  logic w_cs_fall;
  logic w_cs_rise_unused;
  logic w_mosi;
  logic w_mosi_rise_unused;
  logic w_mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(RST_SCK)) u_sync_sck (
    .i_clk    (csi_MCLK_clk),
    .i_rst    (rsi_MRST_reset),
    .i_d      (coe_SPI_sck),
    .o_q      (w_sck_q_unused),
    .o_rise_c (w_sck_rise),
    .o_fall_c (w_sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(RST_CS_N)) u_sync_cs (
    .i_clk    (csi_MCLK_clk),
    .i_rst    (rsi_MRST_reset),
    .i_d      (coe_SPI_cs_n),
    .o_q      (w_cs_q),
    .o_rise_c (w_cs_rise_unused),
    .o_fall_c (w_cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(RST_MOSI)) u_sync_mosi (
    .i_clk    (csi_MCLK_clk),
    .i_rst    (rsi_MRST_reset),
    .i_d      (coe_SPI_mosi),
    .o_q      (w_mosi),
    .o_rise_c (w_mosi_rise_unused),
    .o_fall_c (w_mosi_fall_unused)
  );

  state_t                 r_state;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [BYTE_W-1:0]      r_shift;
  logic                   r_is_wr;
  logic [ADDR_W-1:0]      r_addr;
  logic                   r_read;
  logic                   r_write;
  logic [BYTE_W-1:0]      r_wdata;
  logic                   r_miso;

  logic [BYTE_W-1:0]      w_byte;
  logic [ADDR_W-1:0]      w_addr_next;

  // Byte as it will look once the current MOSI bit is shifted in.
  assign w_byte      = {r_shift[BYTE_W-2:0], w_mosi};
  assign w_addr_next = r_addr + ADDR_W'(1);

  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= RST_BYTE;
      r_is_wr   <= RST_BIT;
      r_addr    <= '0;
      r_read    <= RST_BIT;
      r_write   <= RST_BIT;
      r_wdata   <= RST_BYTE;
      r_miso    <= RST_MISO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_miso <= RST_MISO;
          if (w_cs_fall) begin
            r_bit_cnt <= '0;
            r_state   <= ST_CMD;
          end
        end

        ST_CMD: begin
          if (w_cs_q) begin
            r_state <= ST_IDLE;
          end else if (w_sck_rise) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            if (is_last_bit(r_bit_cnt)) begin
              r_addr  <= w_byte[ADDR_W-1:0];
              r_is_wr <= w_byte[CMD_W_BIT];
              if (w_byte[CMD_W_BIT]) begin
                r_state <= ST_DATA;
              end else begin
                r_read  <= 1'b1;
                r_state <= ST_RD_REQ;
              end
            end
          end
        end

        // Read strobe stays up through waitrequest even if the frame was aborted.
        ST_RD_REQ: begin
          if (!avm_M1_waitrequest) begin
            r_read    <= 1'b0;
            r_shift   <= avm_M1_readdata;
            r_bit_cnt <= '0;
            if (w_cs_q) begin
              r_state <= ST_IDLE;
            end else begin
              r_miso  <= avm_M1_readdata[BYTE_W-1];
              r_state <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (w_cs_q) begin
            r_state <= ST_IDLE;
          end else if (w_sck_rise) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            if (is_last_bit(r_bit_cnt)) begin
              if (r_is_wr) begin
                r_wdata <= w_byte;
                r_write <= 1'b1;
                r_state <= ST_WR_REQ;
              end else begin
`ifdef SPI_AVMM_AUTOINC_EN
                r_addr  <= w_addr_next;
                r_read  <= 1'b1;
                r_state <= ST_RD_REQ;
`else
                r_miso  <= RST_MISO;
                r_state <= ST_DONE;
`endif
              end
            end
          end else if (w_sck_fall && !r_is_wr && (r_bit_cnt != '0)) begin
            // Falls before the first rise of the byte belong to the previous byte.
            r_miso <= r_shift[BYTE_W-1];
          end
        end

        ST_WR_REQ: begin
          if (!avm_M1_waitrequest) begin
            r_write <= 1'b0;
            if (w_cs_q) begin
              r_state <= ST_IDLE;
            end else begin
`ifdef SPI_AVMM_AUTOINC_EN
              r_addr    <= w_addr_next;
              r_bit_cnt <= '0;
              r_state   <= ST_DATA;
`else
              r_state   <= ST_DONE;
`endif
            end
          end
        end

        ST_DONE: begin
          r_miso <= RST_MISO;
          if (w_cs_q) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      // Deselect always releases MISO, whatever the FSM is waiting on.
      if (w_cs_q) begin
        r_miso <= RST_MISO;
      end
    end
  end

  assign coe_SPI_miso     = r_miso;
  assign avm_M1_address   = r_addr;
  assign avm_M1_read      = r_read;
  assign avm_M1_write     = r_write;
  assign avm_M1_writedata = r_wdata;

endmodule

// File: tb/tb_spi_avmm_bridge8.sv
// Scoreboard bench for spi_avmm_bridge8: directed SPI frames, Avalon and MISO monitors.
// Expectations follow SPI_AVMM_AUTOINC_EN when it is defined.
module tb_spi_avmm_bridge8;

  localparam int unsigned ADDR_W      = 7;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int          CLK_HALF    = 5;
  localparam int          SCK_HALF    = 50;
  localparam int          BYTE_GAP    = 200;
  localparam int          FRAME_GAP   = 300;

  typedef struct {
    bit              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]      data;
    int unsigned     cycles;
  } txn_t;

  typedef struct {
    int unsigned nbits;
    logic [31:0] bits;
  } frame_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sck = 1'b0;
  logic              cs_n = 1'b1;
  logic              mosi = 1'b0;
  logic              miso;
  logic [ADDR_W-1:0] address;
  logic              rd;
  logic              wr;
  logic [7:0]        wdata;
  logic [7:0]        rdata;
  logic              waitreq;

  int unsigned stall_n  = 0;
  int unsigned busy_cyc = 0;
  int          n_checks = 0;
  int          n_pass   = 0;

  txn_t   exp_txn[$];
  frame_t exp_frm[$];

  always #CLK_HALF clk = ~clk;

  spi_avmm_bridge8 #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .csi_MCLK_clk       (clk),
    .rsi_MRST_reset     (rst),
    .coe_SPI_sck        (sck),
    .coe_SPI_cs_n       (cs_n),
    .coe_SPI_mosi       (mosi),
    .coe_SPI_miso       (miso),
    .avm_M1_address     (address),
    .avm_M1_read        (rd),
    .avm_M1_write       (wr),
    .avm_M1_writedata   (wdata),
    .avm_M1_readdata    (rdata),
    .avm_M1_waitrequest (waitreq)
  );

  function automatic logic [7:0] rom(input logic [ADDR_W-1:0] a);
    case (int'(a))
      0:       return 8'h5A;
      1:       return 8'h3C;
      3:       return 8'h5A;
      default: return 8'hEE;
    endcase
  endfunction

  // Slave: fixed read data, stall for stall_n cycles of each strobe.
  assign rdata   = rom(address);
  assign waitreq = (rd | wr) && (busy_cyc < stall_n);

  always @(posedge clk) begin
    if (rst || !(rd | wr) || !waitreq) busy_cyc <= 0;
    else                               busy_cyc <= busy_cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Avalon monitor: every accepted strobe is matched against the next expected access.
  int unsigned strobe_cyc = 0;
  always @(negedge clk) begin
    txn_t e;
    if (rst) begin
      strobe_cyc = 0;
    end else if (rd | wr) begin
      strobe_cyc++;
      if (!waitreq) begin
        if (exp_txn.size() == 0) begin
          n_checks++;
          $display("FAIL avm_unexpected: got rd=%0b wr=%0b addr=0x%0h, expected no access", rd, wr, address);
        end else begin
          e = exp_txn.pop_front();
          check("avm_is_write", {31'd0, wr}, {31'd0, e.is_wr});
          check("avm_rd_wr_exclusive", {31'd0, rd & wr}, 32'd0);
          check("avm_address", 32'(address), 32'(e.addr));
          if (e.is_wr) check("avm_writedata", 32'(wdata), 32'(e.data));
          check("avm_strobe_cycles", strobe_cyc, e.cycles);
        end
        strobe_cyc = 0;
      end
    end
  end

  // MISO monitor: collect bits at each SCK rise of a frame, compare on deselect.
  initial begin
    frame_t      e;
    int unsigned nbits;
    logic [31:0] bits;
    forever begin
      @(negedge cs_n);
      nbits = 0;
      bits  = '0;
      forever begin
        @(posedge sck or posedge cs_n);
        if (cs_n) break;
        bits = {bits[30:0], miso};
        nbits++;
      end
      if (exp_frm.size() == 0) begin
        n_checks++;
        $display("FAIL miso_unexpected_frame: got %0d bits 0x%0h, expected no frame", nbits, bits);
      end else begin
        e = exp_frm.pop_front();
        check("miso_frame_bits", nbits, e.nbits);
        check("miso_frame_data", bits, e.bits);
      end
      repeat (SYNC_STAGES + 1) @(posedge clk);
      #1;
      check("miso_low_after_cs_rise", {31'd0, miso}, 32'd0);
    end
  end

  task automatic spi_bits(input logic [7:0] tx, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = tx[i];
      #SCK_HALF sck = 1'b1;
      #SCK_HALF sck = 1'b0;
    end
  endtask

  task automatic frame_begin();
    cs_n = 1'b0;
    #SCK_HALF;
  endtask

  task automatic frame_end();
    #SCK_HALF cs_n = 1'b1;
    #FRAME_GAP;
  endtask

  task automatic push_txn(input bit is_wr, input int addr, input logic [7:0] data, input int unsigned cyc);
    txn_t t;
    t.is_wr = is_wr; t.addr = ADDR_W'(addr); t.data = data; t.cycles = cyc;
    exp_txn.push_back(t);
  endtask

  task automatic push_frm(input int unsigned nbits, input logic [31:0] bits);
    frame_t f;
    f.nbits = nbits; f.bits = bits;
    exp_frm.push_back(f);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read"},      {31'd0, rd},    32'd0);
    check({tag, "_write"},     {31'd0, wr},    32'd0);
    check({tag, "_address"},   32'(address),   32'd0);
    check({tag, "_writedata"}, 32'(wdata),     32'd0);
    check({tag, "_miso"},      {31'd0, miso},  32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #2;

    // Write 0x80, 0xA5
    push_txn(1'b1, 0, 8'hA5, 1);
    push_frm(16, 32'h0000);
    frame_begin(); spi_bits(8'h80, 8); #BYTE_GAP; spi_bits(8'hA5, 8); frame_end();

    // Read 0x03 -> 0x5A
    push_txn(1'b0, 3, 8'h00, 1);
`ifdef SPI_AVMM_AUTOINC_EN
    push_txn(1'b0, 4, 8'h00, 1);
`endif
    push_frm(16, 32'h005A);
    frame_begin(); spi_bits(8'h03, 8); #BYTE_GAP; spi_bits(8'h00, 8); frame_end();

    // Read 0x01 with 5 stall cycles -> 0x3C
    stall_n = 5;
    push_txn(1'b0, 1, 8'h00, 6);
`ifdef SPI_AVMM_AUTOINC_EN
    push_txn(1'b0, 2, 8'h00, 6);
`endif
    push_frm(16, 32'h003C);
    frame_begin(); spi_bits(8'h01, 8); #BYTE_GAP; spi_bits(8'h00, 8); frame_end();
    stall_n = 0;

    // Aborted write after 4 data bits, then a complete one
    push_frm(12, 32'h000);
    frame_begin(); spi_bits(8'h82, 8); #BYTE_GAP; spi_bits(8'h11, 4); frame_end();
    push_txn(1'b1, 2, 8'h11, 1);
    push_frm(16, 32'h0000);
    frame_begin(); spi_bits(8'h82, 8); #BYTE_GAP; spi_bits(8'h11, 8); frame_end();

    // Reset while the read strobe is stalled
    stall_n = 1000;
    push_frm(8, 32'h00);
    frame_begin(); spi_bits(8'h05, 8);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (rd) begin seen = 1'b1; break; end
    end
    check("read_pending_before_reset", {31'd0, seen}, 32'd1);
    check("read_address_before_reset", 32'(address), 32'd5);
    rst = 1'b1;
    @(posedge clk);
    #2;
    check_reset_outputs("midframe_reset");
    rst = 1'b0;
    stall_n = 0;
    frame_end();

    // Read 0x00 after reset -> 0x5A
    push_txn(1'b0, 0, 8'h00, 1);
`ifdef SPI_AVMM_AUTOINC_EN
    push_txn(1'b0, 1, 8'h00, 1);
`endif
    push_frm(16, 32'h005A);
    frame_begin(); spi_bits(8'h00, 8); #BYTE_GAP; spi_bits(8'h00, 8); frame_end();

    // Write 0x84 followed by three data bytes
    push_txn(1'b1, 4, 8'h11, 1);
`ifdef SPI_AVMM_AUTOINC_EN
    push_txn(1'b1, 5, 8'h22, 1);
    push_txn(1'b1, 6, 8'h33, 1);
`endif
    push_frm(32, 32'h0);
    frame_begin();
    spi_bits(8'h84, 8); #BYTE_GAP;
    spi_bits(8'h11, 8); #BYTE_GAP;
    spi_bits(8'h22, 8); #BYTE_GAP;
    spi_bits(8'h33, 8);
    frame_end();

    #1000;
    check("avm_expected_left", exp_txn.size(), 32'd0);
    check("miso_frames_left", exp_frm.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
